// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit producing HI/LO with a start/busy/done handshake
//   clk, reset          clock and synchronous active-high reset
//   start, op, A, B     launch MULT/MULTU/DIV/DIVU (op 00/01/10/11) on A, B; sampled only when idle
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only when idle and not starting
//   busy, done          operation in progress / one-cycle completion pulse
//   div_zero            last completed operation was a divide by zero
//   hi, lo              product high/low halves, or remainder/quotient
module mul_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic is_div, neg_pq, neg_r;
    // multiplicand for multiply, divisor for divide
    logic [N-1:0] opnd;
    // multiply: {partial product, remaining multiplier}; divide: low half shifts dividend out, quotient in
    logic [2*N-1:0] acc;
    logic [N:0] rem;
    logic [N-1:0] a_mag, b_mag, quo, rmd;
    logic [N:0] mul_sum;
    logic [N+1:0] rem_sh, diff;
    logic [2*N-1:0] prod;
    logic last, fits, dz;
    assign busy = state != IDLE;
    assign last = cnt == CW'(N-1);
    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        else if (state == RUN && last) state_nx = FIX;
        else if (state == FIX) state_nx = IDLE;
    end
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    always_comb begin
        a_mag   = (~op[0] & A[N-1]) ? -A : A;
        b_mag   = (~op[0] & B[N-1]) ? -B : B;
        mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = {rem, acc[N-1]};
        diff    = rem_sh - {2'b0, opnd};
        fits    = ~diff[N+1];
        prod    = neg_pq ? -acc : acc;
        quo     = neg_pq ? -acc[N-1:0] : acc[N-1:0];
        // remainder magnitude of a zero divide is |A|, so the sign fixup restores A exactly
        rmd     = neg_r ? -rem[N-1:0] : rem[N-1:0];
        dz      = is_div & ~|opnd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_pq   <= 1'b0;
            neg_r    <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    is_div <= op[1];
                    neg_pq <= ~op[0] & (A[N-1] ^ B[N-1]);
                    neg_r  <= ~op[0] & A[N-1];
                    opnd   <= op[1] ? b_mag : a_mag;
                    acc    <= {{N{1'b0}}, op[1] ? a_mag : b_mag};
                    rem    <= '0;
                    cnt    <= '0;
                end else begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    rem          <= fits ? diff[N:0] : rem_sh[N:0];
                    acc[N-1:0]   <= {acc[N-2:0], fits};
                end else begin
                    acc <= {mul_sum, acc[N-1:1]};
                end
            end else if (state == FIX) begin
                hi       <= is_div ? rmd : prod[2*N-1:N];
                lo       <= is_div ? (dz ? '1 : quo) : prod[N-1:0];
                div_zero <= dz;
                done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    localparam int N = 32;
    logic clk = 1'b0;
    logic reset, start, hi_we, lo_we;
    logic [1:0] op;
    logic [N-1:0] A, B, wdata;
    logic busy, done, div_zero;
    logic [N-1:0] hi, lo;
    logic [N-1:0] exp_hi, exp_lo;
    logic exp_dz;
    int n_cmp = 0;
    int n_bad = 0;
    mul_div_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output logic dz);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = o[1] && b == 0;
        if (!o[1]) return o[0] ? 64'(ua * ub) : 64'(sa * sb);
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (o[0]) return {32'(ua % ub), 32'(ua / ub)};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction
    // called at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit scramble, input bit poke, input bit wr_start);
        logic [63:0] r;
        logic dz;
        r = model(o, a, b, dz);
        start = 1'b1; op = o; A = a; B = b;
        if (wr_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555; end
        @(posedge clk);
        for (int i = 1; i <= N + 2; i++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            if (scramble) begin A = $urandom; B = $urandom; op = 2'($urandom); end
            if (poke && i == 5) begin start = 1'b1; hi_we = 1'b1; wdata = 32'hAAAA; end
            chk("busy", {63'b0, busy}, {63'b0, i <= N + 1});
            chk("done", {63'b0, done}, {63'b0, i == N + 2});
            if (i <= N + 1) begin
                chk("hi_hold", {32'b0, hi}, {32'b0, exp_hi});
                chk("lo_hold", {32'b0, lo}, {32'b0, exp_lo});
            end
        end
        exp_hi = r[63:32]; exp_lo = r[31:0]; exp_dz = dz;
        chk($sformatf("hi op%0d %h/%h", o, a, b), {32'b0, hi}, {32'b0, exp_hi});
        chk($sformatf("lo op%0d %h/%h", o, a, b), {32'b0, lo}, {32'b0, exp_lo});
        chk("div_zero", {63'b0, div_zero}, {63'b0, exp_dz});
    endtask
    task automatic idle_done_check();
        @(negedge clk);
        chk("done_once", {63'b0, done}, 64'd0);
        chk("idle_busy", {63'b0, busy}, 64'd0);
    endtask
    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; A = '0; B = '0; wdata = '0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dz", {63'b0, div_zero}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        go(2'b00, 32'hFFFFFFFF, 32'd5, 0, 0, 0);
        idle_done_check();
        go(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
        idle_done_check();
        go(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
        idle_done_check();
        go(2'b11, 32'd7, 32'd2, 0, 0, 0);
        idle_done_check();
        go(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
        idle_done_check();
        go(2'b10, 32'hFFFFFF00, 32'd0, 0, 0, 0);
        idle_done_check();
        go(2'b11, 32'h1234, 32'd0, 0, 0, 0);
        idle_done_check();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = 32'hCAFE; exp_lo = 32'hCAFE;
        chk("mthi", {32'b0, hi}, {32'b0, exp_hi});
        chk("mtlo", {32'b0, lo}, {32'b0, exp_lo});
        chk("mt_no_done", {63'b0, done}, 64'd0);
        chk("mt_dz_kept", {63'b0, div_zero}, {63'b0, exp_dz});
        go(2'b00, 32'd3, 32'hFFFFFFFC, 0, 1, 1);
        go(2'b01, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0);
        go(2'b11, 32'hFFFFFFFF, 32'd10, 0, 0, 0);
        idle_done_check();
        start = 1'b1; op = 2'b00; A = 32'h1111; B = 32'h2222;
        @(posedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        chk("midrst_dz", {63'b0, div_zero}, 64'd0);
        go(2'b10, 32'd100, 32'hFFFFFFF9, 0, 0, 0);
        idle_done_check();
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 8 == 1) rb = 32'd0;
            if (k % 8 == 3) rb = 32'hFFFFFFFF;
            if (k % 8 == 5) ra = 32'h80000000;
            if (k % 8 == 6) rb = 32'($urandom_range(1, 15));
            go(2'($urandom), ra, rb, k[0], 0, 0);
            if (k % 3 == 0) @(negedge clk);
        end
        idle_done_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
